fetch_sequencer: RTL

Instruction-fetch controller for the 5-stage MIPS core. Owns the PC, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Decode pulls instructions through a valid/ready handshake. The block also applies branch redirects from EXE, halt/resume requests, and an out-of-range fault check.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_sequencer_ifid_reg.sv | 55 +++++
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Encoding is visible on the fsm_state port; keep values stable.
  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0;
  localparam int unsigned DEF_PC_STEP = 4;

  // IF/ID bundle at the core's native 32-bit width.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } ifid_t;

endpackage

// File: rtl/fetch_sequencer_ifid_reg.sv
// IF/ID pipeline register with flush > load > hold priority.
// Latency: 1 cycle from load to visible outputs.
// Backpressure: holds contents whenever neither flush nor load is asserted.
//
// Ports: clk, rst_n; load/flush controls; instr_d/pc_d/pc_next_d capture data;
//        valid/instr/pc/pc_next registered outputs.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [ADDR_W-1:0]  pc_d,
  input  logic [ADDR_W-1:0]  pc_next_d,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_next
);

  // Same layout as fetch_pkg::ifid_t, sized by this instance's parameters.
  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
  } bundle_t;

  bundle_t q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.valid   <= 1'b0;
      q.instr   <= INSTR_W'(NOP_INSTR);
      q.pc      <= '0;
      q.pc_next <= '0;
    end else if (flush) begin
      // Flush only kills the entry; payload is don't-care once invalid.
      q.valid <= 1'b0;
    end else if (load) begin
      q <= '{valid: 1'b1, instr: instr_d, pc: pc_d, pc_next: pc_next_d};
    end
  end

  assign valid   = q.valid;
  assign instr   = q.instr;
  assign pc      = q.pc;
  assign pc_next = q.pc_next;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, reads combinational imem, fills IF/ID; optional perf counters via FETCH_PERF_CNT_EN.
// Latency: 1 cycle from pc on imem_addr to the instruction visible in IF/ID.
// Backpressure: id_ready=0 with a live IF/ID entry freezes pc and IF/ID; nothing lost or duplicated.
//
// Ports: clk, rst_n (async active-low); halt_req (level), resume (pulse);
//        branch_taken/branch_target redirect from EXE; imem_addr/imem_rdata
//        instruction memory; ifid_valid/instr/pc/pc_next to decode with
//        id_ready handshake; fsm_state, fault (sticky) status.
//        With FETCH_PERF_CNT_EN: perf_fetch_cnt, perf_bubble_cnt (saturating).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(DEF_PC_STEP),
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(228)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               id_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_next,
  output logic [1:0]         fsm_state,
  output logic               fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              fault_q;

  logic in_run;
  logic br_ok;
  logic want_load;
  logic bad_pc;
  logic attempt;
  logic cap;
  logic fault_hit;
  logic flush;

  assign in_run    = (state == ST_RUN);
  // Redirects only land while the pipe is live (RUN) or parked (HALTED).
  assign br_ok     = branch_taken && (state == ST_RUN || state == ST_HALTED);
  assign want_load = !ifid_valid || id_ready;
  // Out-of-range or misaligned; the check happens at capture, so a bad
  // branch target or a sequential wrap is caught on the next fetch.
  assign bad_pc    = (pc > LAST_ADDR) || (pc[1:0] != 2'b00);
  // Branch and halt both pre-empt the capture attempt.
  assign attempt   = in_run && !br_ok && !halt_req && want_load;
  assign cap       = attempt && !bad_pc;
  assign fault_hit = attempt && bad_pc;
  // Kill the entry on redirect or fault; otherwise any cycle without a
  // capture lets decode drain a consumed entry.
  assign flush     = br_ok || fault_hit || (!cap && id_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_WAIT;
      pc      <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      if (br_ok) begin
        pc <= branch_target;
      end else if (cap) begin
        pc <= pc + PC_STEP;
      end

      case (state)
        ST_WAIT: state <= ST_RUN;
        ST_RUN: begin
          if (!br_ok) begin
            if (halt_req) begin
              state <= ST_HALTED;
            end else if (fault_hit) begin
              state   <= ST_FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if (resume && !halt_req) begin
            state <= ST_RUN;
          end
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_FAULT;
      endcase
    end
  end

  assign imem_addr = pc;
  assign fsm_state = state;
  assign fault     = fault_q;

  ifid_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cap),
    .flush     (flush),
    .instr_d   (imem_rdata),
    .pc_d      (pc),
    .pc_next_d (pc + PC_STEP),
    .valid     (ifid_valid),
    .instr     (ifid_instr),
    .pc        (ifid_pc),
    .pc_next   (ifid_pc_next)
  );

`ifdef FETCH_PERF_CNT_EN
  // Bubble = any RUN cycle without a capture (stall, flush, halt entry, fault).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (cap && (perf_fetch_cnt != '1)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (in_run && !cap && (perf_bubble_cnt != '1)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
